// File: rtl/wheel_pwm_gen.sv
// wheel_pwm_gen
// ---------------------------------------------------------------------------
// Four-channel PWM generator for the side-wheel H-bridge driver pins.
// A prescaler divides clk by DIV to make PWM counts. PERIOD counts form one
// PWM period. Each channel's active duty is loaded only at the period
// boundary, so a command change in the middle of a period never produces a
// glitch pulse.
//
// Optional feature (compile-time macro WHEEL_RAMP_EN):
//   When defined, each active duty moves toward its target by at most STEP
//   counts per period (soft start / soft reversal).
//   When undefined, the active duty jumps to the target at every boundary.
//
// Parameters:
//   DIV     prescaler, one PWM count every DIV clocks (>= 1)
//   PERIOD  PWM counts per period (2..127); duty is in counts
//   STEP    max change of active duty per period when ramping (1..PERIOD)
//
// Ports:
//   clk           system clock
//   rst_n         synchronous reset, active-low
//   en            1 = run; 0 = outputs low, counters and active duties cleared
//   one_one       duty target, wheel 1 leg 1 (7 bit, saturates at PERIOD)
//   one_two       duty target, wheel 1 leg 2
//   two_one       duty target, wheel 2 leg 1
//   two_two       duty target, wheel 2 leg 2
//   pwm_one_one   PWM pin, wheel 1 leg 1
//   pwm_one_two   PWM pin, wheel 1 leg 2
//   pwm_two_one   PWM pin, wheel 2 leg 1
//   pwm_two_two   PWM pin, wheel 2 leg 2
//   period_start  one-clock pulse on the first clock of each new period
// ---------------------------------------------------------------------------
module wheel_pwm_gen #(
  parameter int DIV    = 50,
  parameter int PERIOD = 100,
  parameter int STEP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] one_one,
  input  logic [6:0] one_two,
  input  logic [6:0] two_one,
  input  logic [6:0] two_two,
  output logic       pwm_one_one,
  output logic       pwm_one_two,
  output logic       pwm_two_one,
  output logic       pwm_two_two,
  output logic       period_start
);

  // A one-bit prescaler counter is kept even for DIV = 1; it then stays at 0
  // and every clock is a tick.
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [6:0]       CNT_LAST = 7'(PERIOD - 1);
  localparam logic [7:0]       PERIOD_8 = 8'(PERIOD);

  // Reject illegal configurations at elaboration time.
  if (DIV < 1 || PERIOD < 2 || PERIOD > 127 || STEP < 1 || STEP > PERIOD) begin : g_bad_cfg
    $error("wheel_pwm_gen: illegal DIV/PERIOD/STEP configuration");
  end

  // Target duty: input clamped to PERIOD. Computed in 8 bits; the result
  // never exceeds PERIOD (<= 127) so it fits back into 7 bits.
  function automatic logic [6:0] sat_target(input logic [6:0] duty);
    logic [7:0] d8;
    d8 = {1'b0, duty};
    if (d8 > PERIOD_8) begin
      d8 = PERIOD_8;
    end
    return d8[6:0];
  endfunction

`ifdef WHEEL_RAMP_EN
  localparam logic [7:0] STEP_8 = 8'(STEP);

  // Move the active duty toward the target by at most STEP. 8-bit
  // arithmetic: act + STEP <= 254 and the subtraction is floored at 0,
  // so neither direction can wrap.
  function automatic logic [6:0] ramp_duty(input logic [6:0] act,
                                           input logic [6:0] tgt);
    logic [7:0] a8;
    logic [7:0] t8;
    logic [7:0] up;
    logic [7:0] dn;
    logic [7:0] res;
    a8  = {1'b0, act};
    t8  = {1'b0, tgt};
    up  = a8 + STEP_8;
    dn  = (a8 > STEP_8) ? (a8 - STEP_8) : 8'd0;
    res = a8;
    if (t8 > a8) begin
      res = (up < t8) ? up : t8;
    end else if (t8 < a8) begin
      res = (dn > t8) ? dn : t8;
    end
    return res[6:0];
  endfunction
`endif

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [6:0]       pwm_cnt_q, pwm_cnt_d;
  logic [3:0][6:0]  act_q, act_d;
  logic [3:0]       pwm_q, pwm_d;
  logic             period_start_q, period_start_d;

  logic             tick;
  logic             boundary;
  logic [3:0][6:0]  duty_in;

  // Channel order: 0 = one_one, 1 = one_two, 2 = two_one, 3 = two_two.
  assign duty_in  = {two_two, two_one, one_two, one_one};

  assign tick     = (div_cnt_q == DIV_LAST);
  assign boundary = tick && (pwm_cnt_q == CNT_LAST);

  always_comb begin
    div_cnt_d      = tick ? '0 : (div_cnt_q + DIV_W'(1));
    pwm_cnt_d      = pwm_cnt_q;
    act_d          = act_q;
    pwm_d          = '0;
    period_start_d = boundary;

    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? 7'd0 : (pwm_cnt_q + 7'd1);
    end

    // Duty targets are only looked at in the boundary clock.
    if (boundary) begin
      for (int i = 0; i < 4; i++) begin
`ifdef WHEEL_RAMP_EN
        act_d[i] = ramp_duty(act_q[i], sat_target(duty_in[i]));
`else
        act_d[i] = sat_target(duty_in[i]);
`endif
      end
    end

    // Compare uses the current count and duty; the pin follows one clock
    // later. act = 0 never matches, act = PERIOD always matches.
    for (int i = 0; i < 4; i++) begin
      pwm_d[i] = (pwm_cnt_q < act_q[i]);
    end

    // Disable overrides tick and boundary in the same clock.
    if (!en) begin
      div_cnt_d      = '0;
      pwm_cnt_d      = 7'd0;
      act_d          = '0;
      pwm_d          = '0;
      period_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q      <= '0;
      pwm_cnt_q      <= 7'd0;
      act_q          <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      act_q          <= act_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_one_one  = pwm_q[0];
  assign pwm_one_two  = pwm_q[1];
  assign pwm_two_one  = pwm_q[2];
  assign pwm_two_two  = pwm_q[3];
  assign period_start = period_start_q;

endmodule

// File: tb/tb_wheel_pwm_gen.sv
// Testbench for wheel_pwm_gen. Two instances share the stimulus:
//   A: DIV=1, PERIOD=100, STEP=10 (directed literal checks + model)
//   B: DIV=3, PERIOD=7,   STEP=2  (prescaler coverage, model only)
module tb_wheel_pwm_gen;

  localparam int A_DIV = 1;
  localparam int A_PER = 100;
  localparam int A_STP = 10;
  localparam int B_DIV = 3;
  localparam int B_PER = 7;
  localparam int B_STP = 2;

`ifdef WHEEL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic [6:0] one_one, one_two, two_one, two_two;

  logic a_11, a_12, a_21, a_22, a_ps;
  logic b_11, b_12, b_21, b_22, b_ps;
  logic [3:0] pwm_a, pwm_b;
  assign pwm_a = {a_22, a_21, a_12, a_11};
  assign pwm_b = {b_22, b_21, b_12, b_11};

  wheel_pwm_gen #(.DIV(A_DIV), .PERIOD(A_PER), .STEP(A_STP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .one_one(one_one), .one_two(one_two), .two_one(two_one), .two_two(two_two),
    .pwm_one_one(a_11), .pwm_one_two(a_12), .pwm_two_one(a_21), .pwm_two_two(a_22),
    .period_start(a_ps)
  );

  wheel_pwm_gen #(.DIV(B_DIV), .PERIOD(B_PER), .STEP(B_STP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .one_one(one_one), .one_two(one_two), .two_one(two_one), .two_two(two_two),
    .pwm_one_one(b_11), .pwm_one_two(b_12), .pwm_two_one(b_21), .pwm_two_two(b_22),
    .period_start(b_ps)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  // c_m counts enabled clocks since counting (re)started. The PWM position
  // is (c / DIV) mod PERIOD; the period boundary is the last clock of each
  // PERIOD*DIV block.
  int         c_m   [2];
  int         act_m [2][4];
  logic [3:0] exp_pwm [2];
  logic       exp_ps  [2];

  function automatic int tgt_of(input int din, input int per);
    return (din > per) ? per : din;
  endfunction

  function automatic int step_toward(input int a, input int t, input int st);
    int d;
    if (!RAMP) return t;
    d = t - a;
    if (d > st)  d = st;
    if (d < -st) d = -st;
    return a + d;
  endfunction

  initial begin : model
    int dv, pr, st, pos;
    bit bnd;
    int din [4];
    forever begin
      @(posedge clk);
      din[0] = one_one; din[1] = one_two; din[2] = two_one; din[3] = two_two;
      for (int k = 0; k < 2; k++) begin
        dv = (k == 0) ? A_DIV : B_DIV;
        pr = (k == 0) ? A_PER : B_PER;
        st = (k == 0) ? A_STP : B_STP;
        if (!rst_n || !en) begin
          c_m[k] = 0;
          for (int j = 0; j < 4; j++) act_m[k][j] = 0;
          exp_pwm[k] = 4'b0;
          exp_ps[k]  = 1'b0;
        end else begin
          pos = (c_m[k] / dv) % pr;
          bnd = ((c_m[k] % (dv * pr)) == (dv * pr - 1));
          for (int j = 0; j < 4; j++) exp_pwm[k][j] = (pos < act_m[k][j]);
          exp_ps[k] = bnd;
          if (bnd)
            for (int j = 0; j < 4; j++)
              act_m[k][j] = step_toward(act_m[k][j], tgt_of(din[j], pr), st);
          c_m[k] = c_m[k] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [4:0] got, expv;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int k = 0; k < 2; k++) begin
          got  = (k == 0) ? {a_ps, pwm_a} : {b_ps, pwm_b};
          expv = {exp_ps[k], exp_pwm[k]};
          n_cmp++;
          if (got !== expv) begin
            n_bad++;
            $display("FAIL cycle_model inst=%0d t=%0t got(ps,pwm)=%b required=%b",
                     k, $time, got, expv);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, expv);
    end
  endtask

  // Advance to the next negedge on which instance A shows period_start.
  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ps && n < 2000);
    if (!a_ps) check("wait_ps_timeout", 0, 1);
  endtask

  // Number of negedges until period_start of A (bounded).
  task automatic count_to_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ps && n < 2000);
  endtask

  // High samples of one A channel over the next A_PER clocks.
  task automatic count_period(input int ch, output int hi);
    hi = 0;
    repeat (A_PER) begin
      @(negedge clk);
      hi += pwm_a[ch];
    end
  endtask

  // Enough boundaries for any ramp in this bench to finish.
  task automatic settle();
    repeat (11) wait_ps();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int n, hi;
    int up_exp [5];
    int dn_exp [6];
    if (RAMP) begin
      up_exp = '{10, 20, 30, 40, 45};
      dn_exp = '{45, 35, 25, 15, 5, 0};
    end else begin
      up_exp = '{45, 45, 45, 45, 45};
      dn_exp = '{45, 0, 0, 0, 0, 0};
    end

    rst_n = 1'b0; en = 1'b1;
    one_one = 7'd0; one_two = 7'd0; two_one = 7'd0; two_two = 7'd0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({a_ps, pwm_a, b_ps, pwm_b}), 0);
    rst_n = 1'b1;

    // Idle: period_start every 100 clocks, pins low.
    count_to_ps(n);
    check("first_ps_after_reset", n, 100);
    count_to_ps(n);
    check("ps_interval", n, 100);

    // Steady duty 30 on one_one; small duty on B via two_one.
    one_one = 7'd30;
    two_one = 7'd3;
    settle();
    count_period(0, hi);
    check("steady_30", hi, 30);

    // Saturation then zero on two_two.
    two_one = 7'd6;
    two_two = 7'd127;
    settle();
    count_period(3, hi);
    check("sat_127", hi, 100);
    two_two = 7'd0;
    settle();
    count_period(3, hi);
    check("zero_duty", hi, 0);

    // Mid-period change 20 -> 80 at count 50.
    one_two = 7'd20;
    settle();
    hi = 0;
    for (int k = 1; k <= A_PER; k++) begin
      @(negedge clk);
      if (k == 50) one_two = 7'd80;
      hi += pwm_a[1];
    end
    check("mid_change_current", hi, 20);
    count_period(1, hi);
    check("mid_change_next", hi, RAMP ? 30 : 80);
    one_two = 7'd0;

    // Ramp sequence 0 -> 45 -> 0 on one_one.
    one_one = 7'd0;
    settle();
    one_one = 7'd45;
    wait_ps();
    for (int p = 0; p < 5; p++) begin
      count_period(0, hi);
      check($sformatf("ramp_up_%0d", p), hi, up_exp[p]);
    end
    one_one = 7'd0;
    for (int p = 0; p < 6; p++) begin
      count_period(0, hi);
      check($sformatf("ramp_down_%0d", p), hi, dn_exp[p]);
    end

    // en drop while pwm_one_one is high, then re-enable.
    one_one = 7'd30;
    settle();
    repeat (10) @(negedge clk);
    check("pre_drop_high", int'(a_11), 1);
    en = 1'b0;
    @(negedge clk);
    check("drop_all_low", int'({a_ps, pwm_a, b_ps, pwm_b}), 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    count_to_ps(n);
    check("reenable_first_ps", n, 100);
    count_period(0, hi);
    check("reenable_first_period", hi, RAMP ? 10 : 30);

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
